if_id_stage_buf: RTL
====================

# if_id_stage_buf

Parametrised IF/ID pipeline stage with a valid/ready handshake, a one-entry skid buffer, branch-mispredict flush and NOP bubble insertion. It sits between the fetch stage and the decode stage. It replaces the enable-gated IF/ID register with back-pressure that never drops or duplicates an instruction. It also presents the instruction pre-split into MIPS fields and counts decode-side stall cycles.

## Interface
- INSTR_W, 32, instruction width (≥32; fields taken from bits [31:0])
- PC_W, 32, width of PC+4 value
- NOP_OPCODE, 6'b111000, opcode of the bubble instruction; bubble = {NOP_OPCODE, (INSTR_W-6) zeros}
- SKID, 1, 1 = two-entry (main + skid) full-throughput buffer; 0 = single register, in_ready combinational from out_ready
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  INSTR_W  fetched instruction
- in_pc  in  PC_W  PC+4 of fetched instruction
- flush  in  1  branch mispredict: discard everything held and arriving this cycle
- out_valid  out  1  decode-side instruction valid
- out_ready  in  1  decode accepts this cycle
- out_instr  out  INSTR_W  instruction to decode (bubble when out_valid=0)
- out_pc  out  PC_W  PC+4 of out_instr
- out_opcode/out_rs/out_rt/out_rd/out_shamt/out_funct  out  6/5/5/5/5/6  fields [31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0] of out_instr
- out_addr  out  16  out_instr[15:0]
- out_jump  out  26  out_instr[25:0]
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Accept = in_valid & in_ready; deliver = out_valid & out_ready.
- SKID=1: in_ready = !skid_valid (registered). On accept with main empty or delivering: data goes to main. Otherwise data goes to skid. On deliver with skid valid: skid moves to main; skid is freed.
- SKID=0: in_ready = !out_valid | out_ready. Main loads on accept. Main empties on deliver without accept.
- Order is strictly FIFO. No instruction is lost or duplicated under any out_ready pattern.
- Flush (highest priority): next cycle main and skid are invalid, out_instr = bubble, out_pc keeps its previous value. An accept in the same cycle is dropped. in_ready is 1 the cycle after a flush.
- Whenever main is invalid, out_instr and all fields show the bubble. Fields are registered together with out_instr, never combinationally from in_instr.
- stall_cnt: +1 per cycle with out_valid & !out_ready. Saturates at all-ones. Cleared only by reset. Flush does not clear it.
- Reset (reset=0 at posedge): out_valid=0, skid invalid, out_instr=bubble, out_opcode=NOP_OPCODE, other fields=0, out_pc=0, stall_cnt=0. in_ready=0 while reset is low, 1 the first cycle after release.
- Reset mid-transfer discards both entries, like flush, and additionally clears out_pc and stall_cnt.

## Timing
- Latency in→out: 1 cycle when the stage is empty (accept at edge N, out_valid at N+1).
- Throughput: 1 instruction/cycle sustained with out_ready=1, both modes.
- SKID=1: absorbs one extra instruction after out_ready falls. in_ready falls the cycle after the skid fills. in_ready has no combinational path from out_ready.
- Flush effect is visible on outputs at the next edge. Flush and reset are sampled only at posedge clk.

## Test plan
- Stream 8 instructions, out_ready=1 -> out_instr appears 1 cycle after each accept, in order, one per cycle; stall_cnt=0.
- SKID=1: out_ready=0 for 3 cycles mid-stream -> in_ready drops after 2 held entries, no loss; resuming delivers in order; stall_cnt=3.
- Flush while both entries full and in_valid=1 -> next cycle out_valid=0, out_opcode=6'b111000, out_instr=32'hE000_0000; the input that cycle is never delivered.
- Apply reset=0 mid-stream -> out_valid=0, out_pc=0, stall_cnt=0, in_ready=0 during reset; in_ready=1 one cycle after release.
- Instruction 32'h012A_4020 (add $t0,$t1,$t2) -> opcode 0, rs 9, rt 10, rd 8, shamt 0, funct 0x20, addr 0x4020, jump 0x12A4020.
- CNT_W=4, hold out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/if_id_stage_buf_if.sv
// IF/ID stage bus: fetch-side handshake, flush, decode-side handshake.
// Also carries the pre-split instruction fields and the stall counter.
interface if_id_stage_buf_if #(
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic [5:0]         out_opcode;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [4:0]         out_shamt;
  logic [5:0]         out_funct;
  logic [15:0]        out_addr;
  logic [25:0]        out_jump;
  logic [CNT_W-1:0]   stall_cnt;

  modport master (
    output in_valid, in_instr, in_pc,
    output flush, out_ready,
    input  in_ready, out_valid,
    input  out_instr, out_pc,
    input  out_opcode, out_rs, out_rt,
    input  out_rd, out_shamt, out_funct,
    input  out_addr, out_jump, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, in_pc,
    input  flush, out_ready,
    output in_ready, out_valid,
    output out_instr, out_pc,
    output out_opcode, out_rs, out_rt,
    output out_rd, out_shamt, out_funct,
    output out_addr, out_jump, stall_cnt
  );
endinterface

// File: rtl/if_id_stage_buf.sv
// IF/ID pipeline register with valid/ready, optional skid entry,
// flush-to-bubble and a saturating decode-stall counter.
module if_id_stage_buf #(
  parameter int                INSTR_W    = 32,
  parameter int                PC_W       = 32,
  parameter logic [5:0]        NOP_OPCODE = 6'b111000,
  parameter int                SKID       = 1,
  parameter int                CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  if_id_stage_buf_if.slave bus
);

  localparam logic [INSTR_W-1:0] BUBBLE =
    {NOP_OPCODE, {(INSTR_W-6){1'b0}}};

  logic               live_q;
  logic               main_v;
  logic [INSTR_W-1:0] main_i;
  logic [PC_W-1:0]    main_p;
  logic               skid_v;
  logic [INSTR_W-1:0] skid_i;
  logic [PC_W-1:0]    skid_p;
  logic [CNT_W-1:0]   cnt;

  logic in_rdy;
  logic acc;
  logic dlv;
  logic ld_in;
  logic ld_skid;
  logic to_skid;
  logic drain;

  // Skid mode keeps in_ready purely registered.
  always_comb begin
    in_rdy = 1'b0;
    if (SKID != 0)
      in_rdy = live_q & ~skid_v;
    else
      in_rdy = live_q & (~main_v | bus.out_ready);
  end

  always_comb begin
    acc     = bus.in_valid & in_rdy;
    dlv     = main_v & bus.out_ready;
    ld_skid = dlv & skid_v;
    ld_in   = acc & (~main_v | dlv);
    to_skid = (SKID != 0) & acc & main_v & ~dlv;
    drain   = dlv & ~acc & ~skid_v;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      live_q <= 1'b0;
      main_v <= 1'b0;
      main_i <= BUBBLE;
      main_p <= '0;
      skid_v <= 1'b0;
      skid_i <= '0;
      skid_p <= '0;
    end else if (bus.flush) begin
      live_q <= 1'b1;
      main_v <= 1'b0;
      main_i <= BUBBLE;
      skid_v <= 1'b0;
    end else begin
      live_q <= 1'b1;
      unique case (1'b1)
        ld_skid: begin
          main_i <= skid_i;
          main_p <= skid_p;
          skid_v <= 1'b0;
        end
        ld_in: begin
          main_v <= 1'b1;
          main_i <= bus.in_instr;
          main_p <= bus.in_pc;
        end
        drain: begin
          main_v <= 1'b0;
          main_i <= BUBBLE;
        end
        default: ;
      endcase
      if (to_skid) begin
        skid_v <= 1'b1;
        skid_i <= bus.in_instr;
        skid_p <= bus.in_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      cnt <= '0;
    else if (main_v & ~bus.out_ready & ~&cnt)
      cnt <= cnt + CNT_W'(1);
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = main_v;
  assign bus.out_instr  = main_i;
  assign bus.out_pc     = main_p;
  assign bus.out_opcode = main_i[31:26];
  assign bus.out_rs     = main_i[25:21];
  assign bus.out_rt     = main_i[20:16];
  assign bus.out_rd     = main_i[15:11];
  assign bus.out_shamt  = main_i[10:6];
  assign bus.out_funct  = main_i[5:0];
  assign bus.out_addr   = main_i[15:0];
  assign bus.out_jump   = main_i[25:0];
  assign bus.stall_cnt  = cnt;

endmodule
